// File: rtl/lcd_ctrl.sv
// HD44780 16x2 write-only controller: init list, then two lines of 16 chars from the string ROM.
// Define LCD_CTRL_AUTO_REFRESH_EN to rewrite the screen every T_REFRESH cycles while idle.
module lcd_ctrl #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_EPW     = 12,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_REFRESH = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] SETUP    = 3'd2;
  localparam logic [2:0] E_HIGH   = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  // Byte steps: 0..3 init list, 4 = 0x80, 5..20 chars 0..15, 21 = 0xC0, 22..37 chars 16..31.
  localparam logic [5:0] STEP_LINE1 = 6'd4;
  localparam logic [5:0] STEP_LINE2 = 6'd21;
  localparam logic [5:0] STEP_LAST  = 6'd37;

  if (T_POWERUP < 1 || T_AS < 1 || T_EPW < 1 || T_CMD < 1 || T_CLEAR < 1 || T_REFRESH < 1)
  begin : g_bad_timing
    $error("lcd_ctrl: all timing parameters must be >= 1");
  end

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  step_q, step_d;
  logic [4:0]  addr_q, addr_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        e_q, e_d;

  logic        adv;
  logic [5:0]  adv_step;
  logic [31:0] hold_last;
  logic        auto_go;

  function automatic logic is_cmd(input logic [5:0] s);
    return (s <= STEP_LINE1) || (s == STEP_LINE2);
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [5:0] s);
    case (s)
      6'd0:    return 8'h38;
      6'd1:    return 8'h0C;
      6'd2:    return 8'h06;
      6'd3:    return 8'h01;
      6'd4:    return 8'h80;
      default: return 8'hC0;
    endcase
  endfunction

  function automatic logic [4:0] char_index(input logic [5:0] s);
    logic [5:0] idx;
    idx = (s < STEP_LINE2) ? (s - 6'd5) : (s - 6'd6);
    return idx[4:0];
  endfunction

  assign hold_last = (!rs_q && data_q == 8'h01) ? (T_CLEAR - 1) : (T_CMD - 1);

`ifdef LCD_CTRL_AUTO_REFRESH_EN
  assign auto_go = (cnt_q == T_REFRESH - 1);
`else
  assign auto_go = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    addr_d   = addr_q;
    rs_d     = rs_q;
    data_d   = data_q;
    e_d      = e_q;
    adv      = 1'b0;
    adv_step = step_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == T_POWERUP - 1) begin
          adv      = 1'b1;
          adv_step = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FETCH: begin
        data_d  = char_data;
        rs_d    = 1'b1;
        state_d = SETUP;
        cnt_d   = '0;
      end
      SETUP: begin
        if (cnt_q == T_AS - 1) begin
          state_d = E_HIGH;
          e_d     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      E_HIGH: begin
        if (cnt_q == T_EPW - 1) begin
          state_d = HOLD;
          e_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q == hold_last) begin
          if (step_q == STEP_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            adv      = 1'b1;
            adv_step = step_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        if (refresh || auto_go) begin
          adv      = 1'b1;
          adv_step = STEP_LINE1;
        end else begin
`ifdef LCD_CTRL_AUTO_REFRESH_EN
          cnt_d = cnt_q + 32'd1;
`endif
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
        step_d  = '0;
        e_d     = 1'b0;
      end
    endcase

    // Commands load the bus straight into SETUP; characters take a FETCH cycle for the ROM lookup.
    if (adv) begin
      step_d = adv_step;
      cnt_d  = '0;
      if (is_cmd(adv_step)) begin
        state_d = SETUP;
        data_d  = cmd_byte(adv_step);
        rs_d    = 1'b0;
      end else begin
        state_d = FETCH;
        addr_d  = char_index(adv_step);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
    end
  end

  assign char_addr = addr_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign lcd_data  = data_q;
  assign busy      = (state_q != DONE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected LCD bytes are queued when a pass is started and popped on each E rise.
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int TP  = 10;
  localparam int TAS = 1;
  localparam int TEP = 2;
  localparam int TCM = 3;
  localparam int TCL = 5;
  localparam int TRF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       refresh;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0] lcd_data;

  logic [7:0] rom [32];

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       chk_gap;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int hi_cnt   = 0;
  int lo_cnt   = 0;
  logic e_prev = 1'b0;
  logic prev_clear = 1'b0;

  lcd_ctrl #(
    .T_POWERUP(TP), .T_AS(TAS), .T_EPW(TEP), .T_CMD(TCM), .T_CLEAR(TCL), .T_REFRESH(TRF)
  ) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .char_addr(char_addr), .char_data(char_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign char_data = rom[char_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d, input logic g);
    exp_t e;
    e.rs = rs;
    e.data = d;
    e.chk_gap = g;
    sb.push_back(e);
  endtask

  task automatic push_pass(input bit with_init);
    if (with_init) begin
      push_byte(1'b0, 8'h38, 1'b0);
      push_byte(1'b0, 8'h0C, 1'b1);
      push_byte(1'b0, 8'h06, 1'b1);
      push_byte(1'b0, 8'h01, 1'b1);
    end
    push_byte(1'b0, 8'h80, with_init);
    for (int i = 0; i < 16; i++) push_byte(1'b1, rom[i], 1'b1);
    push_byte(1'b0, 8'hC0, 1'b1);
    for (int i = 16; i < 32; i++) push_byte(1'b1, rom[i], 1'b1);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (lcd_e) break;
    end
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Byte/timing monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int gap;
    if (rst) begin
      e_prev = 1'b0;
      hi_cnt = 0;
      lo_cnt = 0;
      prev_clear = 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        pulses++;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("byte", 32'({lcd_rs, lcd_data}), 32'({e.rs, e.data}));
          if (e.chk_gap) begin
            gap = (prev_clear ? TCL : TCM) + (e.rs ? 1 : 0) + TAS;
            check("gap", 32'(lo_cnt), 32'(gap));
          end
          prev_clear = !e.rs && (e.data == 8'h01);
        end
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end else if (e_prev) begin
        check("e_width", 32'(hi_cnt), 32'(TEP));
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      e_prev = lcd_e;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    int n, base, k;
    msg = "HVKT-Mat Ma!    Bao cao do an 1!";
    for (int i = 0; i < 32; i++) rom[i] = msg[i];

    rst = 1'b1;
    refresh = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_e",    32'(lcd_e),     32'd0);
    check("rst_rs",   32'(lcd_rs),    32'd0);
    check("rst_rw",   32'(lcd_rw),    32'd0);
    check("rst_data", 32'(lcd_data),  32'h00);
    check("rst_addr", 32'(char_addr), 32'd0);
    check("rst_busy", 32'(busy),      32'd1);
    check("rst_done", 32'(done),      32'd0);

    // Full pass from reset
    push_pass(1'b1);
    rst = 1'b0;
    wait_rise(n);
    check("first_rise", 32'(n), 32'd11);
    wait_done(1000, "pass1_done");
    check("pass1_busy", 32'(busy), 32'd0);
    check("pass1_pulses", 32'(pulses), 32'd38);
    check("pass1_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LCD_CTRL_AUTO_REFRESH_EN
    base = pulses;
    push_pass(1'b0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      k++;
      #1;
      if (busy) break;
    end
    check("auto_delay", 32'(k), 32'(TRF));
    check("auto_data", 32'(lcd_data), 32'h80);
    wait_done(1000, "auto_done");
    check("auto_pulses", 32'(pulses - base), 32'd34);
`else
    base = pulses;
    repeat (40) @(negedge clk);
    check("idle_done", 32'(done), 32'd1);
    check("idle_pulses", 32'(pulses - base), 32'd0);
`endif

    // Refresh in DONE, then a second refresh mid-pass that must be ignored
    base = pulses;
    push_pass(1'b0);
    pulse_refresh();
    check("refresh_busy", 32'(busy), 32'd1);
    check("refresh_done", 32'(done), 32'd0);
    repeat (60) @(negedge clk);
    pulse_refresh();
    wait_done(1000, "refresh_pass_done");
    check("refresh_pulses", 32'(pulses - base), 32'd34);
    check("refresh_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during E high of char 5 (7th pulse of a refresh pass)
    base = pulses;
    push_pass(1'b0);
    pulse_refresh();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #2;
      if (pulses == base + 7 && lcd_e) break;
    end
    check("char5_reached", 32'(pulses - base), 32'd7);
    rst = 1'b1;
    #1;
    check("async_e_drop", 32'(lcd_e), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    base = pulses;
    push_pass(1'b1);
    rst = 1'b0;
    wait_rise(n);
    check("rerun_first_rise", 32'(n), 32'd11);
    wait_done(1000, "rerun_done");
    check("rerun_pulses", 32'(pulses - base), 32'd38);
    check("rerun_sb_empty", 32'(sb.size()), 32'd0);
    check("rw_low", 32'(lcd_rw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
